// File: rtl/puck_pkg.sv
// Shared definitions for the puck engine: state encoding, coordinate width
// and the saturating velocity adder.
package puck_pkg;

  localparam int COORD_W = 10;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_GOAL  = 2'd2;

  // Signed add clipped to [-lim, +lim]; wide enough for any velocity plus kick.
  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b,
                                                 input logic signed [15:0] lim);
    logic signed [15:0] s;
    s = a + b;
    if (s > lim)       return lim;
    else if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/puck_engine_if.sv
// Game-side bus of the puck engine: tick strobe and paddle positions in,
// puck position, state and event pulses out.
interface puck_engine_if
  import puck_pkg::*;
#(
  parameter int N_PAD = 2
);
  logic                       clk_cursor;
  logic [N_PAD*COORD_W-1:0]   pad_x;
  logic [N_PAD*COORD_W-1:0]   pad_y;
  logic [COORD_W-1:0]         dot_x;
  logic [COORD_W-1:0]         dot_y;
  logic [1:0]                 state;
  logic                       hit;
  logic [1:0]                 hit_idx;
  logic                       goal_left;
  logic                       goal_right;

  modport master (
    output clk_cursor, pad_x, pad_y,
    input  dot_x, dot_y, state, hit, hit_idx, goal_left, goal_right
  );

  modport slave (
    input  clk_cursor, pad_x, pad_y,
    output dot_x, dot_y, state, hit, hit_idx, goal_left, goal_right
  );
endinterface

// File: rtl/puck_hit_det.sv
// Single-paddle contact detector: signed offsets from paddle to puck and a
// squared-distance compare against the contact threshold.
module puck_hit_det
  import puck_pkg::*;
#(
  parameter int HIT_R2 = 700
)(
  input  logic [COORD_W-1:0]        dot_x,
  input  logic [COORD_W-1:0]        dot_y,
  input  logic [COORD_W-1:0]        pad_x,
  input  logic [COORD_W-1:0]        pad_y,
  output logic                      hit,
  output logic signed [COORD_W:0]   dx,
  output logic signed [COORD_W:0]   dy
);
  localparam int SQ_W = 2*COORD_W + 2;
  localparam int D2_W = 2*COORD_W + 3;

  logic signed [SQ_W-1:0] dx_e, dy_e, dx2, dy2;
  logic [D2_W-1:0]        d2;

  assign dx   = $signed({1'b0, dot_x}) - $signed({1'b0, pad_x});
  assign dy   = $signed({1'b0, dot_y}) - $signed({1'b0, pad_y});
  assign dx_e = {{(SQ_W-COORD_W-1){dx[COORD_W]}}, dx};
  assign dy_e = {{(SQ_W-COORD_W-1){dy[COORD_W]}}, dy};
  assign dx2  = dx_e * dx_e;
  assign dy2  = dy_e * dy_e;
  assign d2   = {1'b0, dx2} + {1'b0, dy2};
  assign hit  = (d2 <= D2_W'(HIT_R2));

endmodule

// File: rtl/puck_engine.sv
// Puck engine: moves one puck per game tick with paddle kicks, saturating
// velocity, wall reflection, goal detection and serve/goal hold states.
// Optional macro PUCK_FRICTION_EN: every 16th PLAY tick each non-zero
// velocity component steps one toward zero (after the kick, before the move).
module puck_engine
  import puck_pkg::*;
#(
  parameter int N_PAD       = 2,
  parameter int VEL_W       = 5,
  parameter int VMAX        = 7,
  parameter int X_LO        = 234,
  parameter int X_HI        = 694,
  parameter int Y_LO        = 111,
  parameter int Y_HI        = 431,
  parameter int GOAL_YLO    = 246,
  parameter int GOAL_YHI    = 296,
  parameter int CEN_X       = 464,
  parameter int CEN_Y       = 271,
  parameter int HIT_R2      = 700,
  parameter int HIT_SHIFT   = 1,
  parameter int SERVE_VX    = 3,
  parameter int SERVE_VY    = 1,
  parameter int SERVE_TICKS = 4,
  parameter int GOAL_TICKS  = 8
)(
  input logic           clk,
  input logic           clr,
  puck_engine_if.slave  bus
);
  localparam int CNT_W = 8;
  localparam int PW    = COORD_W + 2;

  localparam logic signed [PW-1:0]    XLO_S = PW'(X_LO);
  localparam logic signed [PW-1:0]    XHI_S = PW'(X_HI);
  localparam logic signed [PW-1:0]    YLO_S = PW'(Y_LO);
  localparam logic signed [PW-1:0]    YHI_S = PW'(Y_HI);
  localparam logic [COORD_W-1:0]      XLO_C = COORD_W'(X_LO);
  localparam logic [COORD_W-1:0]      XHI_C = COORD_W'(X_HI);
  localparam logic [COORD_W-1:0]      YLO_C = COORD_W'(Y_LO);
  localparam logic [COORD_W-1:0]      YHI_C = COORD_W'(Y_HI);
  localparam logic [COORD_W-1:0]      GYLO  = COORD_W'(GOAL_YLO);
  localparam logic [COORD_W-1:0]      GYHI  = COORD_W'(GOAL_YHI);
  localparam logic [COORD_W-1:0]      CEN_XC = COORD_W'(CEN_X);
  localparam logic [COORD_W-1:0]      CEN_YC = COORD_W'(CEN_Y);
  localparam logic signed [VEL_W-1:0] SVX   = VEL_W'(SERVE_VX);
  localparam logic signed [VEL_W-1:0] SVY   = VEL_W'(SERVE_VY);
  localparam logic signed [15:0]      VLIM  = 16'(VMAX);

  logic                      prev_q;
  logic [COORD_W-1:0]        dot_x_q, dot_x_d, dot_y_q, dot_y_d;
  logic signed [VEL_W-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [1:0]                state_q, state_d;
  logic                      srv_dir_q, srv_dir_d;   // 1: next serve goes -x
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      hit_q, hit_d, goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic [1:0]                hit_idx_q, hit_idx_d;
  logic                      tick;

  assign tick = bus.clk_cursor & ~prev_q;

  logic [N_PAD-1:0]          pad_hit;
  logic signed [COORD_W:0]   pad_dx [N_PAD];
  logic signed [COORD_W:0]   pad_dy [N_PAD];

  for (genvar g = 0; g < N_PAD; g++) begin : g_pad
    puck_hit_det #(.HIT_R2(HIT_R2)) u_det (
      .dot_x (dot_x_q),
      .dot_y (dot_y_q),
      .pad_x (bus.pad_x[COORD_W*g +: COORD_W]),
      .pad_y (bus.pad_y[COORD_W*g +: COORD_W]),
      .hit   (pad_hit[g]),
      .dx    (pad_dx[g]),
      .dy    (pad_dy[g])
    );
  end

  logic                    kick_any;
  logic [1:0]              kick_idx;
  logic signed [COORD_W:0] kick_dx, kick_dy;

  // Priority select: scanning downward leaves the lowest contacting index.
  always_comb begin
    kick_any = 1'b0;
    kick_idx = 2'd0;
    kick_dx  = '0;
    kick_dy  = '0;
    for (int i = N_PAD-1; i >= 0; i--) begin
      if (pad_hit[i]) begin
        kick_any = 1'b1;
        kick_idx = 2'(i);
        kick_dx  = pad_dx[i];
        kick_dy  = pad_dy[i];
      end
    end
  end

  logic signed [VEL_W-1:0] vx_k, vy_k, vx_n, vy_n, vx_neg, vy_neg;
  logic signed [PW-1:0]    nx, ny;

  // Kicked velocity, clipped to +/-VMAX.
  always_comb begin
    vx_k = vx_q;
    vy_k = vy_q;
    if (kick_any) begin
      vx_k = VEL_W'(sat_add(16'(vx_q), 16'(kick_dx >>> HIT_SHIFT), VLIM));
      vy_k = VEL_W'(sat_add(16'(vy_q), 16'(kick_dy >>> HIT_SHIFT), VLIM));
    end
  end

`ifdef PUCK_FRICTION_EN
  logic [3:0] fric_q, fric_d;
  logic       fric_now;
  assign fric_now = (fric_q == 4'hF);

  // Friction step on the 16th PLAY tick of each group.
  always_comb begin
    vx_n = vx_k;
    vy_n = vy_k;
    if (fric_now) begin
      if (vx_k > 0)      vx_n = vx_k - VEL_W'(1);
      else if (vx_k < 0) vx_n = vx_k + VEL_W'(1);
      if (vy_k > 0)      vy_n = vy_k - VEL_W'(1);
      else if (vy_k < 0) vy_n = vy_k + VEL_W'(1);
    end
  end

  // Friction tick counter: held at zero while serving, counts PLAY ticks.
  always_comb begin
    fric_d = fric_q;
    if (state_q == ST_SERVE)                fric_d = '0;
    else if (state_q == ST_PLAY && tick)    fric_d = fric_q + 1'b1;
  end

  // Friction counter register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) fric_q <= '0;
    else     fric_q <= fric_d;
  end
`else
  assign vx_n = vx_k;
  assign vy_n = vy_k;
`endif

  assign vx_neg = -vx_n;
  assign vy_neg = -vy_n;
  assign nx     = $signed({2'b00, dot_x_q}) + PW'(vx_n);
  assign ny     = $signed({2'b00, dot_y_q}) + PW'(vy_n);

  logic in_mouth;
  assign in_mouth = (dot_y_q >= GYLO) && (dot_y_q <= GYHI);

  // Serve/play/goal state machine and per-tick motion update.
  always_comb begin
    dot_x_d   = dot_x_q;
    dot_y_d   = dot_y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    state_d   = state_q;
    srv_dir_d = srv_dir_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    goal_l_d  = 1'b0;
    goal_r_d  = 1'b0;
    case (state_q)
      ST_SERVE: begin
        dot_x_d = CEN_XC;
        dot_y_d = CEN_YC;
        vx_d    = '0;
        vy_d    = '0;
        if (tick) begin
          if (cnt_q == CNT_W'(SERVE_TICKS-1)) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            vx_d    = srv_dir_q ? -SVX : SVX;
            vy_d    = SVY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          hit_d = kick_any;
          if (kick_any) hit_idx_d = kick_idx;
          vx_d    = vx_n;
          vy_d    = vy_n;
          dot_x_d = nx[COORD_W-1:0];
          dot_y_d = ny[COORD_W-1:0];
          if (nx < XLO_S && in_mouth) begin
            goal_l_d  = 1'b1;
            dot_x_d   = XLO_C;
            dot_y_d   = dot_y_q;
            vx_d      = '0;
            vy_d      = '0;
            state_d   = ST_GOAL;
            cnt_d     = '0;
            srv_dir_d = 1'b1;
          end else if (nx > XHI_S && in_mouth) begin
            goal_r_d  = 1'b1;
            dot_x_d   = XHI_C;
            dot_y_d   = dot_y_q;
            vx_d      = '0;
            vy_d      = '0;
            state_d   = ST_GOAL;
            cnt_d     = '0;
            srv_dir_d = 1'b0;
          end else begin
            if (nx < XLO_S) begin
              dot_x_d = XLO_C;
              vx_d    = vx_neg;
            end else if (nx > XHI_S) begin
              dot_x_d = XHI_C;
              vx_d    = vx_neg;
            end
            if (ny < YLO_S) begin
              dot_y_d = YLO_C;
              vy_d    = vy_neg;
            end else if (ny > YHI_S) begin
              dot_y_d = YHI_C;
              vy_d    = vy_neg;
            end
          end
        end
      end
      ST_GOAL: begin
        vx_d = '0;
        vy_d = '0;
        if (tick) begin
          if (cnt_q == CNT_W'(GOAL_TICKS-1)) begin
            state_d = ST_SERVE;
            cnt_d   = '0;
            dot_x_d = CEN_XC;
            dot_y_d = CEN_YC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_SERVE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous clear to the serve position.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_q    <= 1'b0;
      dot_x_q   <= CEN_XC;
      dot_y_q   <= CEN_YC;
      vx_q      <= '0;
      vy_q      <= '0;
      state_q   <= ST_SERVE;
      srv_dir_q <= 1'b0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= 2'd0;
      goal_l_q  <= 1'b0;
      goal_r_q  <= 1'b0;
    end else begin
      prev_q    <= bus.clk_cursor;
      dot_x_q   <= dot_x_d;
      dot_y_q   <= dot_y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      state_q   <= state_d;
      srv_dir_q <= srv_dir_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      goal_l_q  <= goal_l_d;
      goal_r_q  <= goal_r_d;
    end
  end

  assign bus.dot_x      = dot_x_q;
  assign bus.dot_y      = dot_y_q;
  assign bus.state      = state_q;
  assign bus.hit        = hit_q;
  assign bus.hit_idx    = hit_idx_q;
  assign bus.goal_left  = goal_l_q;
  assign bus.goal_right = goal_r_q;

endmodule

// File: tb/tb_puck_engine.sv
// Directed bench for puck_engine: default build plus a zero-vy serve variant.
module tb_puck_engine;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        cc  = 1'b0;
  logic [19:0] pxa = '0, pya = '0, pxb = '0, pyb = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  puck_engine_if #(.N_PAD(2)) ifa ();
  puck_engine_if #(.N_PAD(2)) ifb ();

  assign ifa.clk_cursor = cc;
  assign ifb.clk_cursor = cc;
  assign ifa.pad_x = pxa;
  assign ifa.pad_y = pya;
  assign ifb.pad_x = pxb;
  assign ifb.pad_y = pyb;

  puck_engine u_dut_a (.clk(clk), .clr(clr), .bus(ifa));
  puck_engine #(.SERVE_VY(0)) u_dut_b (.clk(clk), .clr(clr), .bus(ifb));

  task automatic do_tick;
    @(negedge clk); cc = 1'b1;
    @(negedge clk); cc = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic do_reset;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    pxa = '0; pya = '0;
    do_reset();
    n_checks++;
    if ({ifa.dot_x, ifa.dot_y} !== {10'd464, 10'd271}) begin
      n_fail++; $display("FAIL reset_dot: got (%0d,%0d) expected (464,271)", ifa.dot_x, ifa.dot_y);
    end
    n_checks++;
    if (ifa.state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", ifa.state);
    end
    n_checks++;
    if ({ifa.hit, ifa.hit_idx, ifa.goal_left, ifa.goal_right} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 00000",
                         {ifa.hit, ifa.hit_idx, ifa.goal_left, ifa.goal_right});
    end
    ticks(3);
    n_checks++;
    if (ifa.state !== 2'd0) begin
      n_fail++; $display("FAIL serve_hold: got state %0d expected 0", ifa.state);
    end
    do_tick();
    n_checks++;
    if ({ifa.state, ifa.dot_x, ifa.dot_y} !== {2'd1, 10'd464, 10'd271}) begin
      n_fail++; $display("FAIL serve_to_play: got st=%0d (%0d,%0d) expected st=1 (464,271)",
                         ifa.state, ifa.dot_x, ifa.dot_y);
    end
    do_tick();
    n_checks++;
    if ({ifa.dot_x, ifa.dot_y} !== {10'd467, 10'd272}) begin
      n_fail++; $display("FAIL first_move: got (%0d,%0d) expected (467,272)", ifa.dot_x, ifa.dot_y);
    end
  endtask

  task automatic test_held_strobe;
    @(negedge clk); cc = 1'b1;
    repeat (50) @(negedge clk);
    cc = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ifa.dot_x, ifa.dot_y} !== {10'd470, 10'd273}) begin
      n_fail++; $display("FAIL held_strobe: got (%0d,%0d) expected (470,273)", ifa.dot_x, ifa.dot_y);
    end
  endtask

  task automatic test_walls;
    pxa = '0; pya = '0;
    do_reset();
    ticks(4);
    for (int k = 1; k <= 162; k++) begin
      do_tick();
      if (k == 76) begin
        n_checks++;
        if (ifa.dot_x !== 10'd692) begin
          n_fail++; $display("FAIL wall_x_pre: got %0d expected 692", ifa.dot_x);
        end
      end
      if (k == 77) begin
        n_checks++;
        if ({ifa.state, ifa.goal_right, ifa.dot_x, ifa.dot_y} !== {2'd1, 1'b0, 10'd694, 10'd348}) begin
          n_fail++; $display("FAIL wall_x_clamp: got st=%0d gr=%0d (%0d,%0d) expected st=1 gr=0 (694,348)",
                             ifa.state, ifa.goal_right, ifa.dot_x, ifa.dot_y);
        end
      end
      if (k == 78) begin
        n_checks++;
        if (ifa.dot_x !== 10'd691) begin
          n_fail++; $display("FAIL wall_x_reflect: got %0d expected 691", ifa.dot_x);
        end
      end
      if (k == 160) begin
        n_checks++;
        if ({ifa.dot_x, ifa.dot_y} !== {10'd445, 10'd431}) begin
          n_fail++; $display("FAIL wall_y_reach: got (%0d,%0d) expected (445,431)", ifa.dot_x, ifa.dot_y);
        end
      end
      if (k == 161) begin
        n_checks++;
        if ({ifa.dot_x, ifa.dot_y} !== {10'd442, 10'd431}) begin
          n_fail++; $display("FAIL wall_y_clamp: got (%0d,%0d) expected (442,431)", ifa.dot_x, ifa.dot_y);
        end
      end
      if (k == 162) begin
        n_checks++;
        if ({ifa.dot_x, ifa.dot_y} !== {10'd439, 10'd430}) begin
          n_fail++; $display("FAIL wall_y_reflect: got (%0d,%0d) expected (439,430)", ifa.dot_x, ifa.dot_y);
        end
      end
    end
  endtask

  task automatic test_goal_right;
    pxb = '0; pyb = '0;
    do_reset();
    ticks(4 + 76);
    n_checks++;
    if ({ifb.dot_x, ifb.dot_y} !== {10'd692, 10'd271}) begin
      n_fail++; $display("FAIL goal_approach: got (%0d,%0d) expected (692,271)", ifb.dot_x, ifb.dot_y);
    end
    do_tick();
    n_checks++;
    if ({ifb.goal_right, ifb.goal_left, ifb.state, ifb.dot_x, ifb.dot_y} !==
        {1'b1, 1'b0, 2'd2, 10'd694, 10'd271}) begin
      n_fail++; $display("FAIL goal_event: got gr=%0d gl=%0d st=%0d (%0d,%0d) expected gr=1 gl=0 st=2 (694,271)",
                         ifb.goal_right, ifb.goal_left, ifb.state, ifb.dot_x, ifb.dot_y);
    end
    @(negedge clk);
    n_checks++;
    if (ifb.goal_right !== 1'b0) begin
      n_fail++; $display("FAIL goal_pulse_width: got %0d expected 0", ifb.goal_right);
    end
    ticks(7);
    n_checks++;
    if ({ifb.state, ifb.dot_x} !== {2'd2, 10'd694}) begin
      n_fail++; $display("FAIL goal_hold: got st=%0d x=%0d expected st=2 x=694", ifb.state, ifb.dot_x);
    end
    do_tick();
    n_checks++;
    if ({ifb.state, ifb.dot_x, ifb.dot_y} !== {2'd0, 10'd464, 10'd271}) begin
      n_fail++; $display("FAIL goal_to_serve: got st=%0d (%0d,%0d) expected st=0 (464,271)",
                         ifb.state, ifb.dot_x, ifb.dot_y);
    end
    ticks(5);
    n_checks++;
    if ({ifb.state, ifb.dot_x, ifb.dot_y} !== {2'd1, 10'd467, 10'd271}) begin
      n_fail++; $display("FAIL reserve_dir: got st=%0d (%0d,%0d) expected st=1 (467,271)",
                         ifb.state, ifb.dot_x, ifb.dot_y);
    end
  endtask

  task automatic test_kick_priority;
    pxa = {10'd460, 10'd474}; pya = {10'd271, 10'd271};
    do_reset();
    ticks(5);
    n_checks++;
    if ({ifa.hit, ifa.hit_idx, ifa.dot_x, ifa.dot_y} !== {1'b1, 2'd0, 10'd462, 10'd272}) begin
      n_fail++; $display("FAIL kick_prio: got hit=%0d idx=%0d (%0d,%0d) expected hit=1 idx=0 (462,272)",
                         ifa.hit, ifa.hit_idx, ifa.dot_x, ifa.dot_y);
    end
    @(negedge clk);
    n_checks++;
    if (ifa.hit !== 1'b0) begin
      n_fail++; $display("FAIL hit_pulse_width: got %0d expected 0", ifa.hit);
    end
    pxa = {10'd460, 10'd0}; pya = {10'd271, 10'd0};
    do_reset();
    ticks(5);
    n_checks++;
    if ({ifa.hit, ifa.hit_idx, ifa.dot_x, ifa.dot_y} !== {1'b1, 2'd1, 10'd469, 10'd272}) begin
      n_fail++; $display("FAIL kick_idx1: got hit=%0d idx=%0d (%0d,%0d) expected hit=1 idx=1 (469,272)",
                         ifa.hit, ifa.hit_idx, ifa.dot_x, ifa.dot_y);
    end
  endtask

  task automatic test_saturation;
    pxa = {10'd0, 10'd444}; pya = {10'd0, 10'd271};
    do_reset();
    ticks(5);
    n_checks++;
    if ({ifa.hit, ifa.dot_x, ifa.dot_y} !== {1'b1, 10'd471, 10'd272}) begin
      n_fail++; $display("FAIL sat_pos: got hit=%0d (%0d,%0d) expected hit=1 (471,272)",
                         ifa.hit, ifa.dot_x, ifa.dot_y);
    end
    do_tick();
    n_checks++;
    if ({ifa.hit, ifa.dot_x, ifa.dot_y} !== {1'b0, 10'd478, 10'd273}) begin
      n_fail++; $display("FAIL sat_pos_hold: got hit=%0d (%0d,%0d) expected hit=0 (478,273)",
                         ifa.hit, ifa.dot_x, ifa.dot_y);
    end
    pxa = {10'd0, 10'd490};
    do_reset();
    ticks(5);
    n_checks++;
    if ({ifa.hit, ifa.dot_x, ifa.dot_y} !== {1'b1, 10'd457, 10'd272}) begin
      n_fail++; $display("FAIL sat_neg: got hit=%0d (%0d,%0d) expected hit=1 (457,272)",
                         ifa.hit, ifa.dot_x, ifa.dot_y);
    end
    do_tick();
    n_checks++;
    if ({ifa.dot_x, ifa.dot_y} !== {10'd450, 10'd273}) begin
      n_fail++; $display("FAIL sat_neg_hold: got (%0d,%0d) expected (450,273)", ifa.dot_x, ifa.dot_y);
    end
  endtask

  task automatic test_clr_mid;
    pxa = {10'd0, 10'd490}; pya = {10'd0, 10'd271};
    do_reset();
    ticks(5);
    clr = 1'b1;
    #1;
    n_checks++;
    if ({ifa.state, ifa.hit, ifa.dot_x, ifa.dot_y} !== {2'd0, 1'b0, 10'd464, 10'd271}) begin
      n_fail++; $display("FAIL clr_async: got st=%0d hit=%0d (%0d,%0d) expected st=0 hit=0 (464,271)",
                         ifa.state, ifa.hit, ifa.dot_x, ifa.dot_y);
    end
    @(negedge clk); clr = 1'b0;
    ticks(4);
    n_checks++;
    if ({ifa.state, ifa.dot_x} !== {2'd1, 10'd464}) begin
      n_fail++; $display("FAIL clr_reserve: got st=%0d x=%0d expected st=1 x=464", ifa.state, ifa.dot_x);
    end
  endtask

  initial begin
    test_reset();
    test_held_strobe();
    test_walls();
    test_goal_right();
    test_kick_priority();
    test_saturation();
    test_clr_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
